// File: rtl/cache_fill_fsm_if.sv
// Miss-handler bus: cache lookup/LRU inputs, memory read port and the
// data/tag/LRU array write side, grouped for the cache_fill_fsm.
interface cache_fill_fsm_if #(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 8,
  parameter int IDX_W  = 6
);
  localparam int SEL_W = $clog2(WORDS);

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              way0_isLRU;
  logic              way1_isLRU;
  logic [15:0]       mem_data;
  logic              mem_data_valid;

  logic              fsm_busy;
  logic [IDX_W-1:0]  set_index;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_address;
  logic              data_write;
  logic [SEL_W-1:0]  word_sel;
  logic [15:0]       data_out;
  logic              victim_way;
  logic              tag_write;
  logic              lru_write;
  logic              lru_block0;
  logic              lru_block1;
  logic              fill_done;

  modport master (
    input  miss_detected, miss_address, way0_isLRU, way1_isLRU,
           mem_data, mem_data_valid,
    output fsm_busy, set_index, mem_en, mem_address, data_write, word_sel,
           data_out, victim_way, tag_write, lru_write, lru_block0,
           lru_block1, fill_done
  );

  modport slave (
    output miss_detected, miss_address, way0_isLRU, way1_isLRU,
           mem_data, mem_data_valid,
    input  fsm_busy, set_index, mem_en, mem_address, data_write, word_sel,
           data_out, victim_way, tag_write, lru_write, lru_block0,
           lru_block1, fill_done
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: picks the LRU victim way, streams a block in from memory
// word by word, then commits the tag and makes the filled way MRU.
module cache_fill_fsm #(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 8,
  parameter int IDX_W  = 6
) (
  input  logic            clk,
  input  logic            rst,
  cache_fill_fsm_if.master bus
);
  localparam int SEL_W = $clog2(WORDS);
  localparam int CNT_W = SEL_W + 1;
  localparam int OFF_W = SEL_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  iss_q;
  logic [CNT_W-1:0]  rcv_q;
  logic [ADDR_W-1:0] base_q;

  logic              fsm_busy_q;
  logic [IDX_W-1:0]  set_index_q;
  logic              mem_en_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic              data_write_q;
  logic [SEL_W-1:0]  word_sel_q;
  logic [15:0]       data_out_q;
  logic              victim_way_q;
  logic              tag_write_q;
  logic              lru_write_q;
  logic              lru_block0_q;
  logic              lru_block1_q;
  logic              fill_done_q;

  logic              victim_d;
  logic [ADDR_W-1:0] miss_base_d;
  logic [ADDR_W-1:0] rd_addr_d;

  // Victim selection: only an unambiguous "way1 is LRU" picks way 1.
  always_comb begin
    if (bus.way1_isLRU && !bus.way0_isLRU) begin
      victim_d = 1'b1;
    end else begin
      victim_d = 1'b0;
    end
  end

  // Block-aligned base of the missing address and the next read address.
  always_comb begin
    miss_base_d = {bus.miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    rd_addr_d   = base_q + {{(ADDR_W-CNT_W-1){1'b0}}, iss_q, 1'b0};
  end

  // Fill sequencer with registered outputs; issue and receive run independently.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      iss_q         <= {CNT_W{1'b0}};
      rcv_q         <= {CNT_W{1'b0}};
      base_q        <= {ADDR_W{1'b0}};
      fsm_busy_q    <= 1'b0;
      set_index_q   <= {IDX_W{1'b0}};
      mem_en_q      <= 1'b0;
      mem_address_q <= {ADDR_W{1'b0}};
      data_write_q  <= 1'b0;
      word_sel_q    <= {SEL_W{1'b0}};
      data_out_q    <= 16'h0000;
      victim_way_q  <= 1'b0;
      tag_write_q   <= 1'b0;
      lru_write_q   <= 1'b0;
      lru_block0_q  <= 1'b0;
      lru_block1_q  <= 1'b0;
      fill_done_q   <= 1'b0;
    end else begin
      mem_en_q     <= 1'b0;
      data_write_q <= 1'b0;
      tag_write_q  <= 1'b0;
      lru_write_q  <= 1'b0;
      lru_block0_q <= 1'b0;
      lru_block1_q <= 1'b0;
      fill_done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          fsm_busy_q <= 1'b0;
          iss_q      <= {CNT_W{1'b0}};
          rcv_q      <= {CNT_W{1'b0}};
          if (bus.miss_detected) begin
            // First read goes out directly from the miss address.
            base_q        <= miss_base_d;
            set_index_q   <= bus.miss_address[OFF_W+IDX_W-1:OFF_W];
            victim_way_q  <= victim_d;
            mem_en_q      <= 1'b1;
            mem_address_q <= miss_base_d;
            iss_q         <= CNT_W'(1);
            fsm_busy_q    <= 1'b1;
            state_q       <= FILL;
          end else begin
            state_q <= IDLE;
          end
        end
        FILL: begin
          fsm_busy_q <= 1'b1;
          if (iss_q < CNT_W'(WORDS)) begin
            mem_en_q      <= 1'b1;
            mem_address_q <= rd_addr_d;
            iss_q         <= iss_q + CNT_W'(1);
          end else begin
            iss_q <= iss_q;
          end
          if (bus.mem_data_valid && (rcv_q < CNT_W'(WORDS))) begin
            data_write_q <= 1'b1;
            word_sel_q   <= rcv_q[SEL_W-1:0];
            data_out_q   <= bus.mem_data;
            rcv_q        <= rcv_q + CNT_W'(1);
          end else begin
            rcv_q <= rcv_q;
          end
          // rcv_q reaches WORDS while the last write is on the bus.
          if (rcv_q == CNT_W'(WORDS)) begin
            tag_write_q  <= 1'b1;
            lru_write_q  <= 1'b1;
            fill_done_q  <= 1'b1;
            lru_block0_q <= victim_way_q;
            lru_block1_q <= ~victim_way_q;
            state_q      <= COMMIT;
          end else begin
            state_q <= FILL;
          end
        end
        COMMIT: begin
          fsm_busy_q <= 1'b0;
          iss_q      <= {CNT_W{1'b0}};
          rcv_q      <= {CNT_W{1'b0}};
          state_q    <= IDLE;
        end
        default: begin
          fsm_busy_q <= 1'b0;
          iss_q      <= {CNT_W{1'b0}};
          rcv_q      <= {CNT_W{1'b0}};
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.fsm_busy    = fsm_busy_q;
  assign bus.set_index   = set_index_q;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_address = mem_address_q;
  assign bus.data_write  = data_write_q;
  assign bus.word_sel    = word_sel_q;
  assign bus.data_out    = data_out_q;
  assign bus.victim_way  = victim_way_q;
  assign bus.tag_write   = tag_write_q;
  assign bus.lru_write   = lru_write_q;
  assign bus.lru_block0  = lru_block0_q;
  assign bus.lru_block1  = lru_block1_q;
  assign bus.fill_done   = fill_done_q;
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: each miss pushes its expected reads,
// data writes and commit (with cycle numbers) and a monitor pops on every output event.
module tb_cache_fill_fsm;
  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_pass;

  cache_fill_fsm_if bus ();

  cache_fill_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {int c; logic [15:0] a; logic [5:0] idx;} rd_t;
  typedef struct {int c; logic [2:0] sel; logic [15:0] d;} wr_t;
  typedef struct {int c; logic v;} cm_t;

  rd_t rdq[$];
  wr_t wrq[$];
  cm_t cmq[$];

  logic [15:0] mem_seed;
  logic        inject_valid;
  logic        pipe_v [4];
  logic [15:0] pipe_d [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory model: a read seen in cycle k returns its word in cycle k+4.
  always @(negedge clk) begin
    bus.mem_data_valid = pipe_v[3] | inject_valid;
    bus.mem_data       = pipe_v[3] ? pipe_d[3] : 16'($urandom);
    for (int i = 3; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_d[i] = pipe_d[i-1];
    end
    pipe_v[0] = (bus.mem_en === 1'b1);
    pipe_d[0] = mem_seed + {13'd0, bus.mem_address[3:1]};
  end

  // Monitor: every read, write and commit must match the head of its queue.
  always @(negedge clk) begin
    rd_t r;
    wr_t w;
    cm_t m;
    if (bus.mem_en === 1'b1) begin
      if (rdq.size() == 0) chk("rd_spurious", 64'(bus.mem_en), 64'd0);
      else begin
        r = rdq.pop_front();
        chk("rd_cycle", 64'(cyc), 64'(r.c));
        chk("rd_addr", 64'(bus.mem_address), 64'(r.a));
        chk("rd_set_index", 64'(bus.set_index), 64'(r.idx));
      end
    end
    if (bus.data_write === 1'b1) begin
      if (wrq.size() == 0) chk("wr_spurious", 64'(bus.data_write), 64'd0);
      else begin
        w = wrq.pop_front();
        chk("wr_cycle", 64'(cyc), 64'(w.c));
        chk("wr_word_sel", 64'(bus.word_sel), 64'(w.sel));
        chk("wr_data", 64'(bus.data_out), 64'(w.d));
      end
    end
    if ((bus.tag_write | bus.lru_write | bus.fill_done) === 1'b1) begin
      if (cmq.size() == 0)
        chk("commit_spurious", 64'({bus.tag_write, bus.lru_write, bus.fill_done}), 64'd0);
      else begin
        m = cmq.pop_front();
        chk("commit_cycle", 64'(cyc), 64'(m.c));
        chk("commit_pulses", 64'({bus.tag_write, bus.lru_write, bus.fill_done, bus.fsm_busy}), 64'hF);
        chk("commit_victim", 64'(bus.victim_way), 64'(m.v));
        chk("commit_lru", 64'({bus.lru_block0, bus.lru_block1}), 64'({m.v, ~m.v}));
      end
    end
  end

  function automatic logic [63:0] all_outputs();
    return 64'({bus.fsm_busy, bus.set_index, bus.mem_en, bus.mem_address, bus.data_write,
                bus.word_sel, bus.data_out, bus.victim_way, bus.tag_write, bus.lru_write,
                bus.lru_block0, bus.lru_block1, bus.fill_done});
  endfunction

  // One miss starting in the current (idle) cycle; abort_at>0 resets at that cycle offset.
  task automatic do_fill(input logic [15:0] addr, input logic w0, input logic w1,
                         input logic [15:0] seed, input logic disturb, input int abort_at);
    int          m;
    int          lim;
    logic [15:0] base;
    logic        v;
    m    = cyc;
    lim  = (abort_at > 0) ? m + abort_at : m + 1000;
    base = addr & 16'hFFF0;
    v    = w1 & ~w0;
    mem_seed = seed;
    for (int i = 0; i < 8; i++) begin
      if (m + 1 + i <= lim) rdq.push_back('{m + 1 + i, base + 16'(2 * i), addr[9:4]});
      if (m + 6 + i <= lim) wrq.push_back('{m + 6 + i, 3'(i), seed + 16'(i)});
    end
    if (m + 14 <= lim) cmq.push_back('{m + 14, v});
    bus.miss_detected = 1'b1;
    bus.miss_address  = addr;
    bus.way0_isLRU    = w0;
    bus.way1_isLRU    = w1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      #1;
      bus.way0_isLRU = 1'($urandom);
      bus.way1_isLRU = 1'($urandom);
      if (disturb && k <= 12) begin
        bus.miss_detected = 1'($urandom);
        bus.miss_address  = 16'h0400;
      end else begin
        bus.miss_detected = 1'b0;
      end
      if (k == 1) chk("busy_rise", 64'(bus.fsm_busy), 64'd1);
      if (abort_at > 0) begin
        if (k == abort_at) rst = 1'b0;
        if (k == abort_at + 1) begin
          rst = 1'b1;
          chk("abort_outputs_zero", all_outputs(), 64'd0);
        end
        if (k == abort_at + 6) break;
      end else begin
        if (k == 14) chk("busy_commit", 64'(bus.fsm_busy), 64'd1);
        if (k == 15) chk("busy_fall", 64'(bus.fsm_busy), 64'd0);
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    cyc = 0;
    rst = 1'b0;
    inject_valid = 1'b0;
    mem_seed = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      pipe_v[i] = 1'b0;
      pipe_d[i] = 16'h0000;
    end
    bus.miss_detected  = 1'b0;
    bus.miss_address   = 16'h0000;
    bus.way0_isLRU     = 1'b0;
    bus.way1_isLRU     = 1'b0;
    bus.mem_data       = 16'h0000;
    bus.mem_data_valid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs_zero", all_outputs(), 64'd0);
    rst = 1'b1;
    inject_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("idle_valid_no_write", 64'(bus.data_write), 64'd0);
    end
    inject_valid = 1'b0;
    @(posedge clk);
    #1;

    do_fill(16'h1236, 1'b1, 1'b0, 16'hA000, 1'b0, 0);
    do_fill(16'hFFFE, 1'b0, 1'b1, 16'hB000, 1'b0, 0);
    do_fill(16'h5550, 1'b0, 1'b0, 16'hC000, 1'b0, 0);
    do_fill(16'h7777, 1'b1, 1'b1, 16'hC100, 1'b0, 0);
    do_fill(16'h3AB2, 1'b0, 1'b1, 16'hD000, 1'b1, 0);
    do_fill(16'h2468, 1'b1, 1'b0, 16'hE000, 1'b0, 7);
    do_fill(16'h9ACE, 1'b0, 1'b1, 16'hE100, 1'b0, 0);
    for (int n = 0; n < 6; n++)
      do_fill(16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 0);

    for (int t = 0; t < 50 && (rdq.size() + wrq.size() + cmq.size()) != 0; t++)
      @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("rd_queue_drained", 64'(rdq.size()), 64'd0);
    chk("wr_queue_drained", 64'(wrq.size()), 64'd0);
    chk("commit_queue_drained", 64'(cmq.size()), 64'd0);
    chk("final_idle", 64'(bus.fsm_busy), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss handler for the 2-way, 64-set, 16-byte-block cache; drives the write side of the per-set LRU array.
- On a miss it reads the indexed set's LRU bits to choose the victim way and fetches the block from memory as eight 16-bit words.
- It writes each returned word into the data array, then commits the tag and updates LRU so the filled way becomes MRU.
- Sits between the cache tag/data/LRU arrays and the 4-cycle-latency main memory.

Parameters:
ADDR_W, 16, byte address width
WORDS, 8, 16-bit words per block (offset = addr[3:1])
IDX_W, 6, set index width (index = addr[9:4])

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-low
miss_detected  in  1  level; cache lookup missed for miss_address
miss_address  in  16  byte address of the missing access
way0_isLRU  in  1  LRU array output for the indexed set
way1_isLRU  in  1  LRU array output for the indexed set
mem_data  in  16  memory read data
mem_data_valid  in  1  mem_data valid this cycle
fsm_busy  out  1  fill in progress (stall pipeline)
set_index  out  6  latched set index, drives LRU/tag/data set enable
mem_en  out  1  issue memory read this cycle
mem_address  out  16  read address
data_write  out  1  write one data-array word
word_sel  out  3  word index within block for data_write
data_out  out  16  word to write (registered copy of mem_data)
victim_way  out  1  way being filled (0/1)
tag_write  out  1  one-cycle pulse: write tag+valid of victim_way
lru_write  out  1  one-cycle pulse: LRU array writeEn
lru_block0  out  1  value written as way0 LRU bit
lru_block1  out  1  value written as way1 LRU bit
fill_done  out  1  one-cycle pulse, block installed

Behaviour:
- Reset (rst=0 at clock edge): state IDLE; counters 0; every output 0, including mem_address and set_index.
- States: IDLE, FILL, COMMIT.
- IDLE:
  - On miss_detected=1: latch base = {miss_address[15:4],4'b0}, set_index = miss_address[9:4].
  - Latch victim_way = 1 if way1_isLRU=1 and way0_isLRU=0, else 0; ties (both 0 or both 1) choose way 0.
  - Go to FILL; fsm_busy rises the next cycle.
- FILL:
  - fsm_busy=1. Issue counter iss (0..8): while iss<8, mem_en=1 and mem_address = base + 2*iss, then iss++. Reads go out in 8 consecutive cycles.
  - Receive counter rcv (0..8): each cycle with mem_data_valid=1, the next cycle has data_write=1, word_sel=rcv, data_out=mem_data, and rcv++.
  - Returned words are taken strictly in order. mem_data_valid is ignored once rcv=8.
  - When the 8th write issues, go to COMMIT.
- COMMIT (one cycle):
  - tag_write=1, lru_write=1, fill_done=1, fsm_busy=1.
  - lru_block0 = victim_way, lru_block1 = ~victim_way, so the filled way is MRU.
  - Next state IDLE; counters cleared.
- Timing with 4-cycle memory, miss seen at cycle 0:
  - reads issue at cycles 1-8
  - valid at cycles 5-12
  - data writes at cycles 6-13
  - COMMIT at cycle 14
  - IDLE at cycle 15, fsm_busy=0
- miss_detected or a changed miss_address during FILL/COMMIT: ignored; latched base, index and victim are held.
- mem_data_valid in IDLE: ignored, no data_write.
- Reset mid-FILL or mid-COMMIT: immediate return to IDLE with all outputs 0. No tag or LRU write for the aborted fill. Late valids are ignored.
- Address arithmetic is 16-bit. base has zero offset, so base+14 never carries out of the block.
- Back-to-back misses: a new miss is accepted no earlier than the first IDLE cycle after COMMIT.

Test Plan:
1. Reset with rst=0 for 2 cycles, then rst=1 -> all outputs 0, fsm_busy=0. Drive mem_data_valid=1 in IDLE -> no data_write.
2. Miss at 0x1236, way0_isLRU=1, way1_isLRU=0, memory returns 0xA000+i after 4 cycles:
   - mem_address 0x1230, 0x1232, …, 0x123E on cycles 1-8; set_index=0x23
   - data_write word_sel 0..7 with data 0xA000..0xA007 on cycles 6-13
   - COMMIT at cycle 14: victim_way=0, lru_block0=0, lru_block1=1, tag_write=lru_write=fill_done=1 for exactly one cycle
3. Miss at 0xFFFE with way1_isLRU=1, way0_isLRU=0 -> victim_way=1, addresses 0xFFF0..0xFFFE with no wrap, lru_block0=1 and lru_block1=0 at COMMIT.
4. LRU tie (both 0, then both 1) -> victim_way=0 in both runs.
5. During FILL, toggle miss_detected and change miss_address to 0x0400 -> addresses and set_index unchanged; exactly one fill_done.
6. Assert rst=0 at cycle 7 of a fill, release, keep feeding late mem_data_valid -> IDLE, no tag_write or lru_write. A new miss then completes normally in 15 cycles.
